exprom_ctrl: RTL and testbench

EXPROM_CTRL -- requirements
Module: exprom_ctrl

---
 rtl/exprom_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_exprom_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exprom_ctrl.sv
// rtl/exprom_ctrl.sv - PCI expansion-ROM access controller with byte-lane read-modify-write
//
// Arbitrates between a PCI-target read port and a loader write port in front of a
// synchronous ROM with RD_LAT clock edges of read latency (legal 1..3).
// Ports:
//   clk, rst_n            sole clock (rising edge), synchronous active-low reset
//   rd_req/rd_addr        read request (held until rd_ack), dword address
//   rd_ack/rd_data        one-cycle completion pulse, read word (held afterwards)
//   wr_req/wr_addr/
//   wr_data/wr_be         write request (held until wr_ack), address, data, lane enables
//   wr_ack                one-cycle write completion pulse
//   rom_en/rom_wren/
//   rom_addr/rom_dinp     registered ROM controls, one-to-one with the ROM pins
//   rom_dout              ROM read data
//   busy                  high whenever the controller is not idle
// Configuration:
//   EXPROM_WRITE_EN       defined: writes reach the ROM (full-word or RMW merge).
//                         undefined: writes are acknowledged without ROM access and
//                         rom_wren is tied low.
module exprom_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [8:0]  rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    input  logic        wr_req,
    input  logic [8:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        wr_ack,
    output logic        rom_en,
    output logic        rom_wren,
    output logic [8:0]  rom_addr,
    output logic [31:0] rom_dinp,
    input  logic [31:0] rom_dout,
    output logic        busy
);

`ifdef EXPROM_WRITE_EN
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RD_ISSUE    = 3'd1,
        RD_WAIT     = 3'd2,
        RD_ACK      = 3'd3,
        WR_RMW_RD   = 3'd4,
        WR_RMW_WAIT = 3'd5,
        WR_WRITE    = 3'd6,
        WR_ACK      = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RD_ISSUE    = 3'd1,
        RD_WAIT     = 3'd2,
        RD_ACK      = 3'd3,
        WR_ACK      = 3'd7
    } state_t;
`endif

    // The wait state lasts RD_LAT cycles: the edge ending the issue cycle is the
    // ROM sample edge, and data is captured on the edge ending the last wait cycle.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    state_t     state;
    logic [1:0] wait_cnt;
    logic       last_grant;

`ifdef EXPROM_WRITE_EN
    logic [31:0] wbuf_data;
    logic [3:0]  wbuf_be;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction
`else
    // Write address/data are irrelevant when the ROM cannot be written.
    logic unused_wr;
    assign unused_wr = ^{wr_addr, wr_data, wr_be};
    assign rom_wren  = 1'b0;
    assign rom_dinp  = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            last_grant <= GRANT_WR;
            rd_ack     <= 1'b0;
            wr_ack     <= 1'b0;
            rom_en     <= 1'b0;
            rom_addr   <= 9'h0;
            rd_data    <= 32'h0;
            busy       <= 1'b0;
`ifdef EXPROM_WRITE_EN
            rom_wren   <= 1'b0;
            rom_dinp   <= 32'h0;
            wbuf_data  <= 32'h0;
            wbuf_be    <= 4'h0;
`endif
        end else begin
            // Strobes are single-cycle unless a transition below re-asserts them.
            rd_ack <= 1'b0;
            wr_ack <= 1'b0;
            rom_en <= 1'b0;
`ifdef EXPROM_WRITE_EN
            rom_wren <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Read wins when alone, or when both pend and write went last.
                    if (rd_req && (!wr_req || last_grant == GRANT_WR)) begin
                        state      <= RD_ISSUE;
                        rom_en     <= 1'b1;
                        rom_addr   <= rd_addr;
                        last_grant <= GRANT_RD;
                        busy       <= 1'b1;
                    end else if (wr_req) begin
                        last_grant <= GRANT_WR;
                        busy       <= 1'b1;
`ifdef EXPROM_WRITE_EN
                        wbuf_data <= wr_data;
                        wbuf_be   <= wr_be;
                        if (wr_be == 4'hF) begin
                            state    <= WR_WRITE;
                            rom_en   <= 1'b1;
                            rom_wren <= 1'b1;
                            rom_addr <= wr_addr;
                            rom_dinp <= wr_data;
                        end else if (wr_be == 4'h0) begin
                            state  <= WR_ACK;
                            wr_ack <= 1'b1;
                        end else begin
                            state    <= WR_RMW_RD;
                            rom_en   <= 1'b1;
                            rom_addr <= wr_addr;
                        end
`else
                        state  <= WR_ACK;
                        wr_ack <= 1'b1;
`endif
                    end
                end
                RD_ISSUE: begin
                    state    <= RD_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rd_data <= rom_dout;
                        rd_ack  <= 1'b1;
                        state   <= RD_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RD_ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef EXPROM_WRITE_EN
                WR_RMW_RD: begin
                    state    <= WR_RMW_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                WR_RMW_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rom_dinp <= lane_merge(rom_dout, wbuf_data, wbuf_be);
                        rom_en   <= 1'b1;
                        rom_wren <= 1'b1;
                        state    <= WR_WRITE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                WR_WRITE: begin
                    state  <= WR_ACK;
                    wr_ack <= 1'b1;
                end
`endif
                WR_ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exprom_ctrl.sv
// tb/tb_exprom_ctrl.sv - scoreboard testbench for exprom_ctrl with a behavioural ROM
module tb_exprom_ctrl;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        wr_req;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_ack;
    logic        rom_en;
    logic        rom_wren;
    logic [8:0]  rom_addr;
    logic [31:0] rom_dinp;
    logic [31:0] rom_dout;
    logic        busy;

    always #5 clk = ~clk;

    exprom_ctrl #(.RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .wr_ack(wr_ack),
        .rom_en(rom_en), .rom_wren(rom_wren), .rom_addr(rom_addr),
        .rom_dinp(rom_dinp), .rom_dout(rom_dout), .busy(busy)
    );

    // Behavioural synchronous ROM: output registered on the sample edge, LAT-1 extra stages.
    logic [31:0] mem [512];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (rom_en && rom_wren) mem[rom_addr] <= rom_dinp;
        if (rom_en && !rom_wren) pipe[0] <= mem[rom_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_dout = pipe[LAT-1];

    int nvec = 0;
    int nmis = 0;
    int cyc = 0;
    int en_cnt = 0;
    int wren_cnt = 0;
    logic [8:0] last_en_addr = 9'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t expq[$];

    // Monitor: counts ROM strobes, pops and compares every acknowledged transaction.
    always @(negedge clk) begin
        exp_t e;
        if (rom_en) begin
            en_cnt++;
            last_en_addr = rom_addr;
        end
        if (rom_wren) wren_cnt++;
        if (rd_ack || wr_ack) begin
            if (expq.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_ack: got rd_ack=%b wr_ack=%b with nothing expected", rd_ack, wr_ack);
            end else begin
                e = expq.pop_front();
                chk("ack_kind_wr", {31'h0, wr_ack}, {31'h0, e.is_wr});
                if (!e.is_wr) chk("rd_data", rd_data, e.data);
                if (e.at >= 0) chk("ack_cycle", cyc, e.at);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_ack"}, {31'h0, rd_ack}, 32'h0);
        chk({tag, "_wr_ack"}, {31'h0, wr_ack}, 32'h0);
        chk({tag, "_rom_en"}, {31'h0, rom_en}, 32'h0);
        chk({tag, "_rom_wren"}, {31'h0, rom_wren}, 32'h0);
        chk({tag, "_rom_addr"}, {23'h0, rom_addr}, 32'h0);
        chk({tag, "_rom_dinp"}, rom_dinp, 32'h0);
        chk({tag, "_rd_data"}, rd_data, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Issue one isolated transaction from a negedge in the idle state; delta is the
    // expected number of cycles from issue to the ack cycle.
    task automatic do_op(input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_rd, input int delta);
        bit seen = 0;
        expq.push_back('{is_wr: is_wr, data: exp_rd, at: cyc + delta});
        if (is_wr) begin
            wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
        end else begin
            rd_addr = a; rd_req = 1'b1;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_during_op", {31'h0, busy}, 32'h1);
            if ((is_wr && wr_ack) || (!is_wr && rd_ack)) seen = 1;
        end
        if (!seen) begin
            chk("ack_timeout", 32'h0, 32'h1);
            void'(expq.pop_front());
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic requester(input bit is_wr, input int n);
        for (int k = 0; k < n; k++) begin
            bit seen = 0;
            if (is_wr) begin
                wr_addr = 9'h1F0 + 9'(k); wr_data = 32'h5A00_0000 | 32'(k); wr_be = 4'hF; wr_req = 1'b1;
            end else begin
                rd_addr = 9'h040 + 9'(k); rd_req = 1'b1;
            end
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if ((is_wr && wr_ack) || (!is_wr && rd_ack)) seen = 1;
            end
            if (!seen) chk(is_wr ? "arb_wr_starved" : "arb_rd_starved", 32'h0, 32'h1);
            if (is_wr) wr_req = 1'b0; else rd_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    int e0;
    int w0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[9'h012] = 32'hAA55_0001;
        mem[9'h100] = 32'h1122_3344;
        pipe[0] = 32'h0;

        rst_n = 1'b0;
        rd_req = 1'b1; rd_addr = 9'h1FF;
        wr_req = 1'b1; wr_addr = 9'h1FF; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read of 0x012: one rom_en pulse, ack RD_LAT+2 cycles after grant.
        e0 = en_cnt;
        do_op(1'b0, 9'h012, 32'h0, 4'h0, 32'hAA55_0001, LAT + 2);
        chk("rd012_en_pulses", en_cnt - e0, 1);
        chk("rd012_en_addr", {23'h0, last_en_addr}, 32'h012);
        repeat (3) @(negedge clk);
        chk("rd_data_hold", rd_data, 32'hAA55_0001);

        do_op(1'b0, 9'h1A5, 32'h0, 4'h0, 32'hC000_01A5, LAT + 2);

`ifdef EXPROM_WRITE_EN
        // Full-word write: single write strobe with no read in front of it.
        e0 = en_cnt; w0 = wren_cnt;
        do_op(1'b1, 9'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 2);
        chk("wrF_en_pulses", en_cnt - e0, 1);
        chk("wrF_wren_pulses", wren_cnt - w0, 1);
        do_op(1'b0, 9'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, LAT + 2);

        do_op(1'b1, 9'h100, 32'h1122_3344, 4'hF, 32'h0, 2);
        // Partial write 0101: lanes 0 and 2 from new data, 1 and 3 kept.
        e0 = en_cnt; w0 = wren_cnt;
        do_op(1'b1, 9'h100, 32'hAABB_CCDD, 4'b0101, 32'h0, LAT + 3);
        chk("rmw_en_pulses", en_cnt - e0, 2);
        chk("rmw_wren_pulses", wren_cnt - w0, 1);
        do_op(1'b0, 9'h100, 32'h0, 4'h0, 32'h11BB_33DD, LAT + 2);

        // Empty lane mask: immediate ack, no ROM traffic.
        e0 = en_cnt;
        do_op(1'b1, 9'h100, 32'h0000_0000, 4'h0, 32'h0, 1);
        chk("wr0_en_pulses", en_cnt - e0, 0);

        // Reset while the RMW read is in flight: write must never be issued.
        w0 = wren_cnt;
        wr_addr = 9'h100; wr_data = 32'h0; wr_be = 4'b0011; wr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        wr_req = 1'b0;
        chk_zero("rmw_abort");
        chk("rmw_abort_wren", wren_cnt - w0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, 9'h100, 32'h0, 4'h0, 32'h11BB_33DD, LAT + 2);
`else
        // Writes are swallowed: ack the cycle after grant, ROM untouched.
        e0 = en_cnt;
        do_op(1'b1, 9'h100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
        chk("nowr_en_pulses", en_cnt - e0, 0);
        do_op(1'b1, 9'h100, 32'hAABB_CCDD, 4'b0101, 32'h0, 1);
        chk("nowr_wren_never", wren_cnt, 0);
        do_op(1'b0, 9'h100, 32'h0, 4'h0, 32'h1122_3344, LAT + 2);
`endif

        // Reset while a read waits for ROM data: no ack, all outputs cleared.
        rd_addr = 9'h012; rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        chk_zero("rd_abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters from reset, continuously: strict read/write alternation.
        for (int k = 0; k < 3; k++) begin
            expq.push_back('{is_wr: 1'b0, data: 32'hC000_0040 | 32'(k), at: -1});
            expq.push_back('{is_wr: 1'b1, data: 32'h0, at: -1});
        end
        fork
            requester(1'b0, 3);
            requester(1'b1, 3);
        join
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
